// File: rtl/stack_load_ctrl.sv
// Load sequencer: reads count words from memory starting at base_addr and pushes
// each one into the LIFO/FIFO stage, reporting completion, overflow and mode errors.
module stack_load_ctrl #(
   parameter int ADDR_W    = 8,
   parameter int MEM_DEPTH = 8,
   parameter int CNT_W     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  count,
   input  logic [1:0]        mode,
   input  logic              full,
   output logic              mem_valid,
   output logic              mem_r_w,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        opcode,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              mode_err,
   output logic [CNT_W-1:0]  xfer_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      PUSH = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0]        OP_NIMIC = 2'd0;
   localparam logic [1:0]        OP_PUSH  = 2'd1;
   localparam logic [ADDR_W-1:0] DEPTH    = ADDR_W'(MEM_DEPTH);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  remaining;
   logic              mode_ok;

   function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
      return a % DEPTH;
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      if (a >= DEPTH - 1'b1)
         return '0;
      else
         return a + 1'b1;
   endfunction

   assign mode_ok  = (mode == 2'd1) || (mode == 2'd2);
   assign mem_r_w  = 1'b0;
   assign mem_addr = addr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      mem_valid = 1'b0;
      opcode    = OP_NIMIC;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (!mode_ok || count == '0)
                  state_nx = DONE;
               else
                  state_nx = READ;
            end
         end
         READ: begin
            mem_valid = 1'b1;
            // full already includes the push made just before this read
            state_nx  = full ? DONE : PUSH;
         end
         PUSH: begin
            opcode   = OP_PUSH;
            state_nx = (remaining == CNT_W'(1)) ? DONE : READ;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr      <= '0;
         remaining <= '0;
         xfer_cnt  <= '0;
         overflow  <= 1'b0;
         mode_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr      <= wrap_addr(base_addr);
                  remaining <= count;
                  xfer_cnt  <= '0;
                  overflow  <= 1'b0;
                  mode_err  <= !mode_ok;
               end
            end
            READ: begin
               if (full)
                  overflow <= 1'b1;
            end
            PUSH: begin
               addr      <= next_addr(addr);
               remaining <= remaining - 1'b1;
               xfer_cnt  <= xfer_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_load_ctrl.sv
// Bench for stack_load_ctrl: memory and stack environment plus a load-level reference model.
module tb_stack_load_ctrl;
   localparam int ADDR_W    = 8;
   localparam int MEM_DEPTH = 8;
   localparam int CNT_W     = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  count;
   logic [1:0]        mode;
   logic              full;
   logic              mem_valid;
   logic              mem_r_w;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        opcode;
   logic              busy;
   logic              done;
   logic              overflow;
   logic              mode_err;
   logic [CNT_W-1:0]  xfer_cnt;

   stack_load_ctrl #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
      .mode(mode), .full(full), .mem_valid(mem_valid), .mem_r_w(mem_r_w),
      .mem_addr(mem_addr), .opcode(opcode), .busy(busy), .done(done),
      .overflow(overflow), .mode_err(mode_err), .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;

   // environment: word memory with registered read, stack with capacity cap
   logic [7:0]        mem [MEM_DEPTH];
   int                cap = 8;
   int                stack_level = 0;
   int                stk_init = 0;
   logic              stk_load = 1'b0;
   logic [ADDR_W-1:0] last_rd = '0;
   int                pushed[$];

   assign full = (stack_level >= cap);

   always @(posedge clk) begin
      if (stk_load) begin
         stack_level <= stk_init;
         pushed.delete();
      end else if (opcode == 2'd1) begin
         stack_level <= stack_level + 1;
         pushed.push_back(int'(mem[int'(last_rd) % MEM_DEPTH]));
      end
      if (mem_valid)
         last_rd <= mem_addr;
   end

   int checks = 0;
   int errors = 0;

   // reference model results
   int exp_lat, exp_n;
   bit exp_ovf, exp_merr;
   int exp_reads[$];
   int exp_data[$];

   // observations of one load
   int obs_lat, obs_bad;
   bit obs_timeout;
   logic obs_done2, obs_busy2;
   int obs_reads[$];

   task automatic model(input int b, input int c, input int m, input int lvl, input int cp);
      int room;
      exp_reads.delete();
      exp_data.delete();
      exp_merr = !(m == 1 || m == 2);
      exp_n = 0;
      exp_ovf = 0;
      exp_lat = 1;
      if (!exp_merr && c != 0) begin
         room = (cp > lvl) ? cp - lvl : 0;
         exp_n = (c < room) ? c : room;
         exp_ovf = (c > exp_n);
         exp_lat = 2 * exp_n + 1 + (exp_ovf ? 1 : 0);
         for (int i = 0; i < exp_n + (exp_ovf ? 1 : 0); i++) begin
            exp_reads.push_back((b + i) % MEM_DEPTH);
            if (i < exp_n) exp_data.push_back(int'(mem[(b + i) % MEM_DEPTH]));
         end
      end
   endtask

   task automatic prep(input int lvl, input int cp);
      cap = cp;
      stk_init = lvl;
      stk_load = 1'b1;
      @(posedge clk); #1;
      stk_load = 1'b0;
   endtask

   task automatic run_load(input int b, input int c, input int m, input bit noise);
      int cyc;
      @(posedge clk); #1;
      base_addr = ADDR_W'(b);
      count = CNT_W'(c);
      mode = 2'(m);
      start = 1'b1;
      @(posedge clk); #1;
      cyc = 1;
      start = 1'b0;
      obs_reads.delete();
      obs_bad = 0;
      obs_timeout = 0;
      forever begin
         if (mem_valid) obs_reads.push_back(int'(mem_addr));
         if (mem_r_w !== 1'b0 || opcode > 2'd1 || busy !== 1'b1 || (mem_valid && opcode != 2'd0))
            obs_bad++;
         if (done === 1'b1) break;
         if (cyc >= 80) begin obs_timeout = 1; break; end
         if (noise) begin
            start = 1'($urandom);
            base_addr = ADDR_W'($urandom);
            count = CNT_W'($urandom);
            mode = 2'($urandom);
         end
         @(posedge clk); #1;
         cyc++;
      end
      obs_lat = cyc;
      start = 1'b0;
      @(posedge clk); #1;
      obs_done2 = done;
      obs_busy2 = busy;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      base_addr = '0;
      count = '0;
      mode = '0;
      #22;
      checks++;
      if ({mem_valid, mem_r_w, mem_addr, opcode, busy, done, overflow, mode_err, xfer_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %b required all zero",
                  {mem_valid, mem_r_w, mem_addr, opcode, busy, done, overflow, mode_err, xfer_cnt});
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, mem_valid} !== 3'b000) begin
         errors++;
         $display("FAIL idle_after_reset: got %b required 000", {busy, done, mem_valid});
      end
   endtask

   task automatic test_lifo_basic();
      mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
      prep(0, 4);
      model(0, 4, 1, 0, 4);
      run_load(0, 4, 1, 0);
      checks++;
      if (obs_lat !== exp_lat) begin errors++; $display("FAIL lifo_latency: got %0d required %0d", obs_lat, exp_lat); end
      checks++;
      if (obs_reads != exp_reads) begin errors++; $display("FAIL lifo_reads: got %p required %p", obs_reads, exp_reads); end
      checks++;
      if (pushed != exp_data) begin errors++; $display("FAIL lifo_data: got %p required %p", pushed, exp_data); end
      checks++;
      if ({full, overflow, mode_err, int'(xfer_cnt)} !== {1'b1, exp_ovf, exp_merr, exp_n}) begin
         errors++;
         $display("FAIL lifo_flags: got full=%b ovf=%b merr=%b xfer=%0d required full=1 ovf=%b merr=%b xfer=%0d",
                  full, overflow, mode_err, xfer_cnt, exp_ovf, exp_merr, exp_n);
      end
      checks++;
      if (obs_bad !== 0 || obs_done2 !== 1'b0 || obs_busy2 !== 1'b0) begin
         errors++;
         $display("FAIL lifo_strobes: got bad=%0d done2=%b busy2=%b required 0 0 0", obs_bad, obs_done2, obs_busy2);
      end
   endtask

   task automatic test_fifo_overflow();
      prep(0, 4);
      model(0, 5, 2, 0, 4);
      run_load(0, 5, 2, 0);
      checks++;
      if (obs_lat !== exp_lat) begin errors++; $display("FAIL ovf_latency: got %0d required %0d", obs_lat, exp_lat); end
      checks++;
      if (obs_reads != exp_reads) begin errors++; $display("FAIL ovf_reads: got %p required %p", obs_reads, exp_reads); end
      checks++;
      if (pushed.size() !== exp_n) begin errors++; $display("FAIL ovf_pushes: got %0d required %0d", pushed.size(), exp_n); end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (overflow !== exp_ovf || int'(xfer_cnt) !== exp_n) begin
         errors++;
         $display("FAIL ovf_sticky: got ovf=%b xfer=%0d required ovf=%b xfer=%0d", overflow, xfer_cnt, exp_ovf, exp_n);
      end
   endtask

   task automatic test_count_zero();
      prep(0, 8);
      model(3, 0, 1, 0, 8);
      run_load(3, 0, 1, 0);
      checks++;
      if (obs_lat !== exp_lat || obs_reads.size() != 0 || pushed.size() != 0) begin
         errors++;
         $display("FAIL zero_count: got lat=%0d reads=%0d pushes=%0d required lat=%0d reads=0 pushes=0",
                  obs_lat, obs_reads.size(), pushed.size(), exp_lat);
      end
      checks++;
      if (xfer_cnt !== '0 || overflow !== exp_ovf || mode_err !== exp_merr) begin
         errors++;
         $display("FAIL zero_flags: got xfer=%0d ovf=%b merr=%b required 0 %b %b", xfer_cnt, overflow, mode_err, exp_ovf, exp_merr);
      end
   endtask

   task automatic test_mode_err();
      for (int k = 0; k < 2; k++) begin
         prep(0, 8);
         model(1, 3, k * 3, 0, 8);
         run_load(1, 3, k * 3, 0);
         repeat (2) @(posedge clk);
         #1;
         checks++;
         if (obs_lat !== exp_lat || obs_reads.size() != 0 || mode_err !== exp_merr || obs_bad !== 0) begin
            errors++;
            $display("FAIL mode_err_%0d: got lat=%0d reads=%0d merr=%b bad=%0d required lat=%0d reads=0 merr=%b bad=0",
                     k * 3, obs_lat, obs_reads.size(), mode_err, obs_bad, exp_lat, exp_merr);
         end
      end
      prep(0, 8);
      model(2, 1, 1, 0, 8);
      run_load(2, 1, 1, 0);
      checks++;
      if (mode_err !== exp_merr || int'(xfer_cnt) !== exp_n) begin
         errors++;
         $display("FAIL mode_err_clear: got merr=%b xfer=%0d required merr=%b xfer=%0d", mode_err, xfer_cnt, exp_merr, exp_n);
      end
   endtask

   task automatic test_wrap();
      int bases[2] = '{6, 14};
      foreach (bases[i]) begin
         prep(0, 8);
         model(bases[i], 3, 2, 0, 8);
         run_load(bases[i], 3, 2, 0);
         checks++;
         if (obs_reads != exp_reads) begin
            errors++;
            $display("FAIL wrap_base%0d: got %p required %p", bases[i], obs_reads, exp_reads);
         end
      end
   endtask

   task automatic test_reset_mid_load();
      prep(0, 8);
      @(posedge clk); #1;
      base_addr = 8'd2; count = 4'd4; mode = 2'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (opcode !== 2'd1) begin errors++; $display("FAIL mid_reset_pos: got opcode=%0d required 1", opcode); end
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if ({mem_valid, mem_r_w, mem_addr, opcode, busy, done, overflow, mode_err, xfer_cnt} !== '0) begin
         errors++;
         $display("FAIL mid_reset_async: got %b required all zero",
                  {mem_valid, mem_r_w, mem_addr, opcode, busy, done, overflow, mode_err, xfer_cnt});
      end
      @(negedge clk);
      reset = 1'b0;
      prep(0, 8);
      model(5, 2, 2, 0, 8);
      run_load(5, 2, 2, 0);
      checks++;
      if (obs_reads != exp_reads || int'(xfer_cnt) !== exp_n || obs_lat !== exp_lat) begin
         errors++;
         $display("FAIL post_reset_load: got reads=%p xfer=%0d lat=%0d required reads=%p xfer=%0d lat=%0d",
                  obs_reads, xfer_cnt, obs_lat, exp_reads, exp_n, exp_lat);
      end
   endtask

   task automatic test_random();
      int b, c, m, cp, lvl;
      for (int it = 0; it < 25; it++) begin
         for (int j = 0; j < MEM_DEPTH; j++) mem[j] = 8'($urandom);
         b = $urandom_range(0, 255);
         c = $urandom_range(0, 15);
         m = $urandom_range(0, 3);
         if ($urandom_range(0, 3) != 0) m = 1 + $urandom_range(0, 1);
         cp = $urandom_range(1, 8);
         lvl = $urandom_range(0, cp);
         prep(lvl, cp);
         model(b, c, m, lvl, cp);
         run_load(b, c, m, 1);
         checks++;
         if (obs_timeout || obs_lat !== exp_lat) begin
            errors++;
            $display("FAIL rand%0d_latency: got %0d timeout=%b required %0d", it, obs_lat, obs_timeout, exp_lat);
         end
         checks++;
         if (obs_reads != exp_reads) begin errors++; $display("FAIL rand%0d_reads: got %p required %p", it, obs_reads, exp_reads); end
         checks++;
         if (pushed != exp_data) begin errors++; $display("FAIL rand%0d_data: got %p required %p", it, pushed, exp_data); end
         checks++;
         if (overflow !== exp_ovf || mode_err !== exp_merr || int'(xfer_cnt) !== exp_n) begin
            errors++;
            $display("FAIL rand%0d_status: got ovf=%b merr=%b xfer=%0d required ovf=%b merr=%b xfer=%0d",
                     it, overflow, mode_err, xfer_cnt, exp_ovf, exp_merr, exp_n);
         end
         checks++;
         if (obs_bad !== 0 || obs_done2 !== 1'b0 || obs_busy2 !== 1'b0) begin
            errors++;
            $display("FAIL rand%0d_strobes: got bad=%0d done2=%b busy2=%b required 0 0 0", it, obs_bad, obs_done2, obs_busy2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lifo_basic();
      test_fifo_overflow();
      test_count_zero();
      test_mode_err();
      test_wrap();
      test_reset_mid_load();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
